// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial MSB-first magnitude comparator.
package cmp_pkg;

  localparam int unsigned CMP_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Returns {EQ, GT} from the less-significant stage; eq dominates gt.
  function automatic logic [1:0] resolve_cascade(input logic eq_in, input logic gt_in);
    return eq_in ? 2'b10 : {1'b0, gt_in};
  endfunction

endpackage

// File: rtl/cmp1_cell.sv
// One-bit compare cell: flags a bit mismatch and whether A's bit is the larger.
module cmp1_cell (
  input  logic ai,
  input  logic bi,
  output logic diff,
  output logic agtb
);

  assign diff = ai ^ bi;
  assign agtb = ai & ~bi;

endmodule

// File: rtl/serial_cmp8.sv
// Bit-serial magnitude comparator: walks captured operands MSB first, stops at the first
// differing bit, and falls back to the cascade flags when all bits match.
module serial_cmp8
  import cmp_pkg::*;
#(
  parameter int unsigned W = CMP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:W-1]           a,
  input  logic [0:W-1]           b,
  input  logic                   eq,
  input  logic                   gt,
  output logic                   busy,
  output logic                   done,
  output logic                   EQ,
  output logic                   GT,
  output logic [$clog2(W+1)-1:0] nbits
);

  localparam int unsigned NW = $clog2(W + 1);
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  state_e        r_state, w_state_d;
  logic [0:W-1]  r_a, r_b;
  logic          r_eq, r_gt;
  logic [IW-1:0] r_idx, w_idx_d;
  logic          r_eq_res, w_eq_res_d;
  logic          r_gt_res, w_gt_res_d;
  logic [NW-1:0] r_nbits, w_nbits_d;
  logic          w_capture;
  logic          w_diff, w_agtb, w_last;

  cmp1_cell u_cell (
    .ai   (r_a[r_idx]),
    .bi   (r_b[r_idx]),
    .diff (w_diff),
    .agtb (w_agtb)
  );

  assign w_last = (r_idx == IW'(W - 1));

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_eq_res_d = r_eq_res;
    w_gt_res_d = r_gt_res;
    w_nbits_d  = r_nbits;
    w_capture  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_capture = 1'b1;
          w_idx_d   = '0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (w_diff) begin
          w_eq_res_d = 1'b0;
          w_gt_res_d = w_agtb;
          w_nbits_d  = NW'(r_idx) + NW'(1);
          w_state_d  = StDone;
        end else if (w_last) begin
          {w_eq_res_d, w_gt_res_d} = resolve_cascade(r_eq, r_gt);
          w_nbits_d = NW'(W);
          w_state_d = StDone;
        end else begin
          w_idx_d = r_idx + IW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_idx    <= '0;
      r_eq_res <= 1'b0;
      r_gt_res <= 1'b0;
      r_nbits  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_eq_res <= w_eq_res_d;
      r_gt_res <= w_gt_res_d;
      r_nbits  <= w_nbits_d;
      if (w_capture) begin
        r_a  <= a;
        r_b  <= b;
        r_eq <= eq;
        r_gt <= gt;
      end
    end
  end

  assign busy  = (r_state != StIdle);
  assign done  = (r_state == StDone);
  assign EQ    = r_eq_res;
  assign GT    = r_gt_res;
  assign nbits = r_nbits;

endmodule

// File: tb/tb_serial_cmp8.sv
// Scoreboard bench for serial_cmp8: stimulus pushes model results, a negedge monitor
// pops and checks them on every done pulse.
module tb_serial_cmp8;

  localparam int unsigned W  = 8;
  localparam int unsigned NW = $clog2(W + 1);

  typedef struct packed {
    logic          eq;
    logic          gt;
    logic [NW-1:0] nbits;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, eq, gt;
  logic [0:W-1]  a, b;
  logic          busy, done, EQ, GT;
  logic [NW-1:0] nbits;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t last;
  int   busy_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  serial_cmp8 #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .eq    (eq),
    .gt    (gt),
    .busy  (busy),
    .done  (done),
    .EQ    (EQ),
    .GT    (GT),
    .nbits (nbits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: numeric comparison; nbits is the MSB-first position of the first differing bit.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic e, input logic g);
    exp_t       r;
    logic [7:0] x;
    x = av ^ bv;
    if (x == 8'd0) begin
      r.nbits = NW'(W);
      if (e) begin
        r.eq = 1'b1;
        r.gt = 1'b0;
      end else begin
        r.eq = 1'b0;
        r.gt = g;
      end
    end else begin
      r.eq    = 1'b0;
      r.gt    = (av > bv);
      r.nbits = NW'(W - $clog2(int'(x) + 1) + 1);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      last     = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("EQ", EQ, mon_exp.eq);
          check("GT", GT, mon_exp.gt);
          check("nbits", nbits, mon_exp.nbits);
          check("busy_cycles", busy_cnt, mon_exp.nbits + 1);
        end
        busy_cnt   = 0;
        last.eq    = EQ;
        last.gt    = GT;
        last.nbits = nbits;
      end else begin
        check("hold", {EQ, GT, nbits}, last);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv,
                         input logic e, input logic g);
    wait_idle();
    a     = av;
    b     = bv;
    eq    = e;
    gt    = g;
    start = 1'b1;
    exp_q.push_back(model(av, bv, e, g));
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after capture; the result must not follow them.
    a  = 8'($urandom);
    b  = 8'($urandom);
    eq = 1'($urandom);
    gt = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] av, bv;
    int         n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    eq    = 1'b0;
    gt    = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_EQ", EQ, 0);
    check("rst_GT", GT, 0);
    check("rst_nbits", nbits, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    run_cmp(8'h00, 8'h00, 1'b1, 1'b0);
    run_cmp(8'h01, 8'h00, 1'b1, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0, 1'b0);
    run_cmp(8'h00, 8'h00, 1'b0, 1'b1);
    run_cmp(8'h00, 8'h00, 1'b0, 1'b0);
    run_cmp(8'h00, 8'h00, 1'b1, 1'b1);

    // start held through the whole comparison, a changed mid-SHIFT
    wait_idle();
    a     = 8'h5A;
    b     = 8'h5A;
    eq    = 1'b0;
    gt    = 1'b1;
    start = 1'b1;
    exp_q.push_back(model(8'h5A, 8'h5A, 1'b0, 1'b1));
    @(negedge clk);
    @(negedge clk);
    a = 8'hA5;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_done_seen", done, 1);
    start = 1'b0;

    // Leave EQ=1 so the reset-abort check sees outputs actually drop.
    run_cmp(8'h00, 8'h00, 1'b1, 1'b1);
    wait_idle();
    a     = 8'h3C;
    b     = 8'h3C;
    eq    = 1'b0;
    gt    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_EQ", EQ, 0);
    check("abort_GT", GT, 0);
    check("abort_nbits", nbits, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    run_cmp(8'h02, 8'h03, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      av = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = av ^ (8'h01 << $urandom_range(0, 7));
        default: bv = 8'($urandom);
      endcase
      run_cmp(av, bv, 1'($urandom), 1'($urandom));
    end

    wait_idle();
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
